// File: rtl/mont_modexp_ctrl.sv
// Montgomery-domain square-and-multiply sequencer driving one external multiplier.
// Define MODEXP_SKIP_LZ_EN to enable leading-zero skipping of the exponent (SCAN state).
module mont_modexp_ctrl #(
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic [15:0]          op_count,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    localparam int unsigned CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(EXP_WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_SQ,
        S_WAIT_SQ,
        S_MUL,
        S_WAIT_MUL,
        S_NEXT,
        S_FIN,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     x_reg;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH-1:0]     acc;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [CW-1:0]        bit_cnt;
    logic [WIDTH-1:0]     op_b;
    logic                 e_msb;
    logic                 e_zero;

    assign e_msb  = e_reg[EXP_WIDTH-1];
    assign e_zero = (e_reg == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MODEXP_SKIP_LZ_EN
                    state_next = S_SCAN;
`else
                    state_next = S_SQ;
`endif
                end
            end
            S_SCAN: begin
                if (e_zero) begin
                    state_next = S_FIN;
                end else if (e_msb) begin
                    state_next = S_SQ;
                end
            end
            S_SQ:       state_next = S_WAIT_SQ;
            S_WAIT_SQ: begin
                if (mm_done) begin
                    state_next = e_msb ? S_MUL : S_NEXT;
                end
            end
            S_MUL:      state_next = S_WAIT_MUL;
            S_WAIT_MUL: begin
                if (mm_done) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT:     state_next = (bit_cnt == '0) ? S_FIN : S_SQ;
            S_FIN:      state_next = S_WAIT_FIN;
            S_WAIT_FIN: begin
                if (mm_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Operand B of the next multiply: A (square), X (multiply) or 1 (leave Montgomery domain).
    always_comb begin
        op_b = acc;
        if (state == S_MUL) begin
            op_b = x_reg;
        end else if (state == S_FIN) begin
            op_b = ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_reg    <= '0;
            m_reg    <= '0;
            acc      <= '0;
            e_reg    <= '0;
            bit_cnt  <= '0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        x_reg    <= in_x;
                        m_reg    <= in_m;
                        e_reg    <= in_e;
                        acc      <= in_r;
                        bit_cnt  <= CNT_INIT;
                        op_count <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (!e_zero && !e_msb && (bit_cnt != '0)) begin
                        e_reg   <= e_reg << 1;
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                S_SQ, S_MUL, S_FIN: begin
                    mm_start <= 1'b1;
                    mm_a     <= acc;
                    mm_b     <= op_b;
                    mm_m     <= m_reg;
                    if (op_count != '1) begin
                        op_count <= op_count + 16'd1;
                    end
                end
                S_WAIT_SQ, S_WAIT_MUL: begin
                    if (mm_done) begin
                        acc <= mm_result;
                    end
                end
                S_NEXT: begin
                    if (bit_cnt != '0) begin
                        e_reg   <= e_reg << 1;
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                S_WAIT_FIN: begin
                    if (mm_done) begin
                        result <= mm_result;
                        done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Self-checking bench for mont_modexp_ctrl with a behavioural 5-cycle Montgomery multiplier.
// Expected results come from plain modular exponentiation in the normal domain.
module tb_mont_modexp_ctrl;

    localparam int W  = 1024;
    localparam int EW = 1024;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_r = '0;
    logic [EW-1:0] in_e = '0;
    logic [W-1:0]  in_m = '0;
    logic [W-1:0]  result;
    logic          done;
    logic          busy;
    logic [15:0]   op_count;
    logic          mm_start;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic [W-1:0]  mm_m;
    logic [W-1:0]  mm_result = '0;
    logic          mm_done = 1'b0;

    mont_modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_m(in_m),
        .result(result), .done(done), .busy(busy), .op_count(op_count),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act[199:0], req[199:0]);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout required done", name);
    endtask

    // a*b*2^-W mod m by bitwise halving
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        logic [2*W-1:0] p;
        logic [W:0]     t;
        if (m == '0) return '0;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, m};
        t = p[W:0];
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + {1'b0, m};
            t = t >> 1;
        end
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] modpow(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] r, b, mm;
        mm = {{W{1'b0}}, m};
        r  = (2*W)'(1) % mm;
        b  = {{W{1'b0}}, x} % mm;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {x, {W{1'b0}}} % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] r_of(input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = (2*W)'(1) << W;
        p = p % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    function automatic int exp_ops(input logic [EW-1:0] e);
        int h, s;
        h = 0;
        s = 0;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) begin
                h++;
                s = i + 1;
            end
        end
`ifndef MODEXP_SKIP_LZ_EN
        s = EW;
`endif
        return s + h + 1;
    endfunction

    // Behavioural multiplier: done rises 5 cycles after mm_start rises.
    logic [W-1:0] ma, mb, mmod;
    int           mcnt = 0;
    always @(posedge clk) begin
        mm_done <= 1'b0;
        if (mm_start) begin
            ma   <= mm_a;
            mb   <= mm_b;
            mmod <= mm_m;
            mcnt <= 4;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mm_done   <= 1'b1;
                mm_result <= mont(ma, mb, mmod);
            end
        end
    end

    // Handshake monitor: no second start before done, operands frozen while waiting.
    int           done_pulses = 0;
    logic         pend = 1'b0;
    logic         moved = 1'b0;
    logic [W-1:0] la, lb, lm;
    always @(negedge clk) begin
        if (!resetn) begin
            pend  = 1'b0;
            moved = 1'b0;
        end else begin
            if (done) done_pulses++;
            if (mm_start) begin
                check("mm_start_overlap", W'(pend), '0);
                pend  = 1'b1;
                moved = 1'b0;
                la    = mm_a;
                lb    = mm_b;
                lm    = mm_m;
            end else if (pend && (mm_a !== la || mm_b !== lb || mm_m !== lm)) begin
                moved = 1'b1;
            end
            if (mm_done && pend) begin
                check("mm_operands_stable", W'(moved), '0);
                pend = 1'b0;
            end
        end
    end

    task automatic launch(input logic [W-1:0] m, input logic [W-1:0] x, input logic [EW-1:0] e);
        @(negedge clk);
        in_m  = m;
        in_x  = to_mont(x, m);
        in_r  = r_of(m);
        in_e  = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] m, input logic [W-1:0] x,
                                 input logic [EW-1:0] e, input logic [W-1:0] y, input int ops);
        int d0;
        bit ok;
        d0 = done_pulses;
        launch(m, x, e);
        check({tag, "_busy"}, W'(busy), W'(1));
        wait_done(ok);
        if (!ok) begin
            fail_timeout({tag, "_done"});
            return;
        end
        check({tag, "_result"}, result, y);
        check({tag, "_op_count"}, W'(op_count), W'(ops));
        @(negedge clk);
        check({tag, "_idle_after"}, W'({busy, done}), '0);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, W'(done_pulses - d0), W'(1));
    endtask

    typedef struct {
        string         name;
        logic [W-1:0]  m;
        logic [W-1:0]  x;
        logic [EW-1:0] e;
        logic [W-1:0]  y;
        int            ops;
    } vec_t;

    vec_t         tbl[3];
    int           ops5, ops0, ops7;
    logic [W-1:0] big_m, big_x;
    int           d0;
    bit           ok;

    initial begin
`ifdef MODEXP_SKIP_LZ_EN
        ops5 = 6;    ops0 = 1;    ops7 = 7;
`else
        ops5 = 1027; ops0 = 1025; ops7 = 1028;
`endif
        tbl[0] = '{name: "e5_m13",  m: W'(13), x: W'(3), e: EW'(5), y: W'(9),  ops: ops5};
        tbl[1] = '{name: "e0_m13",  m: W'(13), x: W'(6), e: EW'(0), y: W'(1),  ops: ops0};
        tbl[2] = '{name: "e7_m17",  m: W'(17), x: W'(3), e: EW'(7), y: W'(11), ops: ops7};

        repeat (3) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_op_count", W'(op_count), '0);
        check("reset_flags", W'({busy, done, mm_start}), '0);
        check("reset_mm_ops", mm_a | mm_b | mm_m, '0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run_and_check(tbl[i].name, tbl[i].m, tbl[i].x, tbl[i].e, tbl[i].y, tbl[i].ops);
        end

        // start re-pulsed while busy and during the DONE cycle
        d0 = done_pulses;
        launch(W'(13), W'(3), EW'(5));
        repeat (20) @(negedge clk);
        in_e = EW'(7); in_x = W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        if (!ok) begin
            fail_timeout("busy_done");
        end else begin
            check("busy_result", result, W'(9));
            check("busy_op_count", W'(op_count), W'(ops5));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_low_after_done", W'(busy), '0);
            repeat (20) @(negedge clk);
            check("done_cycle_start_ignored", W'({busy, mm_start}), '0);
            check("busy_done_pulses", W'(done_pulses - d0), W'(1));
        end

        // reset while waiting for the X multiply
        launch(W'(13), W'(3), EW'(5));
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (mm_start && mm_b == in_x && mm_a != mm_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_timeout("reset_mul_reach");
        end else begin
            repeat (2) @(negedge clk);
            resetn = 1'b0;
            #1;
            check("rst_mid_result", result, '0);
            check("rst_mid_op_count", W'(op_count), '0);
            check("rst_mid_flags", W'({busy, done, mm_start}), '0);
            check("rst_mid_mm_ops", mm_a | mm_b | mm_m, '0);
            repeat (2) @(negedge clk);
            resetn = 1'b1;
            d0 = done_pulses;
            repeat (12) @(negedge clk);
            check("stale_mm_done_ignored", W'({busy, done, mm_start}), '0);
            check("stale_done_pulses", W'(done_pulses - d0), '0);
            run_and_check("after_reset", W'(13), W'(3), EW'(5), W'(9), ops5);
        end

        // full-width random modulus and base, e = 65537
        for (int i = 0; i < W / 32; i++) begin
            big_m[i*32 +: 32] = $urandom;
            big_x[i*32 +: 32] = $urandom;
        end
        big_m[W-1] = 1'b1;
        big_m[0]   = 1'b1;
        big_x      = big_x % big_m;
        run_and_check("wide_e65537", big_m, big_x, EW'(65537), modpow(big_x, EW'(65537), big_m),
                      exp_ops(EW'(65537)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
